// File: rtl/uart_rx_word_demux_pkg.sv
// Shared types for the UART receive word demultiplexer: FSM states,
// destination select codes (same encoding as the TX output mux) and byte-count helper.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      COMMIT  = 2'd2
   } rx_state_e;

   localparam logic [1:0] DST_A = 2'b00;
   localparam logic [1:0] DST_B = 2'b01;
   localparam logic [1:0] DST_C = 2'b10;
   localparam logic [1:0] DST_D = 2'b11;

   function automatic int nbytes(input int length);
      return length / 8;
   endfunction

endpackage

// File: rtl/uart_rx_word_demux_if.sv
// Byte-strobe input side and destination-register output side of the RX word demux.
// master drives bytes (receiver side), slave is the demux itself.
interface uart_rx_word_demux_if #(
   parameter int LENGTH = 32
);
   logic              enable;
   logic [7:0]        rx_data;
   logic              rx_done;
   logic [1:0]        sel;
   logic [LENGTH-1:0] A;
   logic [LENGTH-1:0] B;
   logic [LENGTH-1:0] C;
   logic [LENGTH-1:0] D;
   logic [3:0]        word_valid;
   logic              busy;
   logic              err;

   modport master (
      output enable, rx_data, rx_done, sel,
      input  A, B, C, D, word_valid, busy, err
   );

   modport slave (
      input  enable, rx_data, rx_done, sel,
      output A, B, C, D, word_valid, busy, err
   );
endinterface

// File: rtl/uart_rx_word_demux_assembler.sv
// Little-endian byte-to-word assembler: a start byte clears the word and lands in
// bits [7:0]; later bytes fill upward. done_o flags the byte that completes a word.
module uart_byte_assembler
   import uart_rx_pkg::*;
#(
   parameter int LENGTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              accept_i,
   input  logic              start_i,
   input  logic [7:0]        rx_data_i,
   output logic [LENGTH-1:0] word_o,
   output logic              done_o
);
   localparam int NBYTES = nbytes(LENGTH);
   localparam int CNT_W  = $clog2(NBYTES) + 1;

   logic [LENGTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (accept_i) begin
         if (start_i) begin
            // Clearing the upper bytes keeps a dropped partial word from leaking in.
            shift_d      = '0;
            shift_d[7:0] = rx_data_i;
            cnt_d        = CNT_W'(1);
         end else begin
            for (int k = 0; k < NBYTES; k++) begin
               if (cnt_q == CNT_W'(k)) shift_d[8*k +: 8] = rx_data_i;
            end
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign done_o = accept_i && (cnt_d == CNT_W'(NBYTES));
   assign word_o = shift_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_word_demux.sv
// Assembles LENGTH-bit words from UART RX byte strobes and routes each to holding
// register A..D by sel. Optional inter-byte timeout enabled by macro RX_TIMEOUT_EN.
module uart_rx_word_demux
   import uart_rx_pkg::*;
#(
   parameter int LENGTH      = 32,
   parameter int TIMEOUT_CYC = 100000
) (
   input logic                 clk,
   input logic                 rst,
   uart_rx_word_demux_if.slave bus
);
   rx_state_e         state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [LENGTH-1:0] dst_q [4];
   logic [LENGTH-1:0] dst_d [4];
   logic [3:0]        word_valid_q, word_valid_d;
   logic              accept, start, done, timeout;
   logic [LENGTH-1:0] word;

   assign accept = bus.enable && bus.rx_done;
   // Any byte outside COLLECT opens a new word, including one arriving during COMMIT.
   assign start  = accept && (state_q != COLLECT);

   uart_byte_assembler #(
      .LENGTH(LENGTH)
   ) u_asm (
      .clk       (clk),
      .rst       (rst),
      .accept_i  (accept),
      .start_i   (start),
      .rx_data_i (bus.rx_data),
      .word_o    (word),
      .done_o    (done)
   );

`ifdef RX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;

   always_comb begin
      tmo_d   = tmo_q;
      timeout = 1'b0;
      if (state_q != COLLECT || accept) begin
         tmo_d = '0;
      end else if (bus.enable) begin
         if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            timeout = 1'b1;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
      err_d = timeout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign timeout = 1'b0;
   assign bus.err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      dst_d        = dst_q;
      word_valid_d = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sel_d   = bus.sel;
               state_d = done ? COMMIT : COLLECT;
            end
         end
         COLLECT: begin
            if (accept && done) state_d = COMMIT;
            else if (timeout)   state_d = IDLE;
         end
         COMMIT: begin
            // Delivery ignores enable so a finished word is never lost.
            dst_d[sel_q]        = word;
            word_valid_d[sel_q] = 1'b1;
            if (accept) begin
               sel_d   = bus.sel;
               state_d = done ? COMMIT : COLLECT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         dst_q        <= '{default: '0};
         word_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         dst_q        <= dst_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign bus.A          = dst_q[DST_A];
   assign bus.B          = dst_q[DST_B];
   assign bus.C          = dst_q[DST_C];
   assign bus.D          = dst_q[DST_D];
   assign bus.word_valid = word_valid_q;
   assign bus.busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_uart_rx_word_demux.sv
// Bench for uart_rx_word_demux (LENGTH=32): table-driven words plus hand-written
// corner sequences, with a scoreboard queue checked whenever word_valid pulses.
module tb_uart_rx_word_demux;

   localparam int LEN = 32;
   localparam int TMO = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b0;

   typedef struct {
      logic [1:0]  dst;
      logic [31:0] word;
      int          cyc;
   } sb_t;

   typedef struct {
      logic [1:0]  sel0;
      logic [1:0]  sel_rest;
      logic [31:0] word;
      int          gap;
      logic [1:0]  exp_dst;
   } vec_t;

   sb_t         sb_q[$];
   sb_t         e_mon;
   logic [31:0] model [4];
   vec_t        vecs [5];

   uart_rx_word_demux_if #(.LENGTH(LEN)) bus ();

   uart_rx_word_demux #(
      .LENGTH      (LEN),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [1:0] s);
      bus.enable  = 1'b1;
      bus.rx_data = b;
      bus.sel     = s;
      bus.rx_done = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.enable  = 1'b1;
      bus.rx_done = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] d, input logic [31:0] w);
      sb_t e;
      e.dst  = d;
      e.word = w;
      e.cyc  = cyc;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: every delivered word is matched against the queue, and the
   // four destinations must equal the model on every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.word_valid !== 4'b0000) begin
            if (sb_q.size() == 0) begin
               check("spurious_word_valid", bus.word_valid, 4'b0000);
            end else begin
               e_mon = sb_q.pop_front();
               check("word_valid_onehot", bus.word_valid, 4'b0001 << e_mon.dst);
               check("commit_latency", cyc - e_mon.cyc, 1);
               model[e_mon.dst] = e_mon.word;
            end
         end
         check("dst_regs", {bus.A, bus.B, bus.C, bus.D}, {model[0], model[1], model[2], model[3]});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int err_cnt;

      vecs[0] = '{sel0: 2'b10, sel_rest: 2'b10, word: 32'h12345678, gap: 0, exp_dst: 2'b10};
      vecs[1] = '{sel0: 2'b00, sel_rest: 2'b11, word: 32'hDEADBEEF, gap: 0, exp_dst: 2'b00};
      vecs[2] = '{sel0: 2'b01, sel_rest: 2'b01, word: 32'hA5A50FF0, gap: 3, exp_dst: 2'b01};
      vecs[3] = '{sel0: 2'b11, sel_rest: 2'b00, word: 32'h00000080, gap: 1, exp_dst: 2'b11};
      vecs[4] = '{sel0: 2'b10, sel_rest: 2'b01, word: 32'hFFFFFFFF, gap: 0, exp_dst: 2'b10};

      for (int i = 0; i < 4; i++) model[i] = '0;
      bus.enable  = 1'b1;
      bus.rx_done = 1'b0;
      bus.rx_data = '0;
      bus.sel     = '0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_dst", {bus.A, bus.B, bus.C, bus.D}, 128'd0);
      check("rst_word_valid", bus.word_valid, 4'b0000);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_err", bus.err, 1'b0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // Table-driven words, LSB first; sel changes after byte 0 must be ignored
      for (int v = 0; v < 5; v++) begin
         send_byte(vecs[v].word[7:0], vecs[v].sel0);
         @(negedge clk);
         check("busy_mid_word", bus.busy, 1'b1);
         for (int k = 1; k < 4; k++) begin
            if (vecs[v].gap > 0) idle(vecs[v].gap);
            send_byte(vecs[v].word[8*k +: 8], vecs[v].sel_rest);
         end
         push(vecs[v].exp_dst, vecs[v].word);
         idle(3);
         check("busy_after_word", bus.busy, 1'b0);
      end

      // enable low freezes collection; only bytes 1,2,5,6 build the word
      send_byte(8'h01, 2'b01);
      send_byte(8'h02, 2'b01);
      for (int i = 0; i < 50; i++) begin
         bus.enable  = 1'b0;
         bus.rx_done = (i % 3 == 0);
         bus.rx_data = 8'($urandom);
         bus.sel     = 2'($urandom);
         @(posedge clk);
         #1;
      end
      bus.rx_done = 1'b0;
      @(negedge clk);
      check("busy_while_disabled", bus.busy, 1'b1);
      send_byte(8'h05, 2'b11);
      send_byte(8'h06, 2'b11);
      push(2'b01, 32'h06050201);
      idle(3);

      // Mid-word reset drops the partial word and clears destinations
      send_byte(8'hAA, 2'b00);
      send_byte(8'hBB, 2'b00);
      send_byte(8'hCC, 2'b00);
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      sb_q.delete();
      @(negedge clk);
      check("busy_after_midword_rst", bus.busy, 1'b0);
      check("dst_after_midword_rst", {bus.A, bus.B, bus.C, bus.D}, 128'd0);
      mon_en = 1'b1;
      send_byte(8'h44, 2'b01);
      send_byte(8'h33, 2'b01);
      send_byte(8'h22, 2'b01);
      send_byte(8'h11, 2'b01);
      push(2'b01, 32'h11223344);
      idle(3);

      // Byte arriving in the COMMIT cycle starts the next word
      send_byte(8'h0D, 2'b00);
      send_byte(8'hF0, 2'b00);
      send_byte(8'hFE, 2'b00);
      send_byte(8'hCA, 2'b00);
      push(2'b00, 32'hCAFEF00D);
      send_byte(8'h21, 2'b11);
      @(negedge clk);
      check("busy_after_commit_byte", bus.busy, 1'b1);
      send_byte(8'h43, 2'b00);
      send_byte(8'h65, 2'b00);
      send_byte(8'h87, 2'b00);
      push(2'b11, 32'h87654321);
      idle(3);

      // Inter-byte idle: timeout build discards, default build keeps waiting
      send_byte(8'h01, 2'b10);
      send_byte(8'h02, 2'b10);
      err_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.err === 1'b1) err_cnt++;
      end
      @(posedge clk);
      #1;
`ifdef RX_TIMEOUT_EN
      check("timeout_err_pulses", err_cnt, 1);
      @(negedge clk);
      check("timeout_busy", bus.busy, 1'b0);
      send_byte(8'hEF, 2'b10);
      send_byte(8'hCD, 2'b10);
      send_byte(8'hAB, 2'b10);
      send_byte(8'h89, 2'b10);
      push(2'b10, 32'h89ABCDEF);
`else
      check("no_timeout_err", err_cnt, 0);
      @(negedge clk);
      check("no_timeout_busy", bus.busy, 1'b1);
      send_byte(8'h03, 2'b00);
      send_byte(8'h04, 2'b00);
      push(2'b10, 32'h04030201);
`endif
      idle(5);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_word_demux.md
Name: uart_rx_word_demux

Overview:
Receive-side counterpart of the TX output mux in the MIPS_UART path. Takes byte strobes from the UART receiver and assembles LENGTH-bit words from consecutive bytes, least-significant byte first. Routes each completed word to one of four holding registers (A..D) chosen by sel, and pulses a per-destination valid flag. Feeds MIPS-side data and command registers from the serial link.

Parameters:
LENGTH, 32, word width in bits; must be a multiple of 8 and at least 8.
TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles; used only with RX_TIMEOUT_EN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  when low, rx_done is ignored and all state is held.
rx_data  input  8  received byte; valid only while rx_done is high.
rx_done  input  1  one-cycle strobe from the UART receiver.
sel  input  2  destination: 00=A, 01=B, 10=C, 11=D.
A, B, C, D  output  LENGTH  destination holding registers.
word_valid  output  4  one-hot, one-cycle pulse; bit i marks an update of destination i (bit0=A).
busy  output  1  high while a partial word is held (state COLLECT).
err  output  1  one-cycle pulse when a partial word is discarded on timeout; constant 0 without the macro.

Behaviour:
- Derived constant: NBYTES = LENGTH/8. Byte counter width is clog2(NBYTES)+1.
- Reset, synchronous: A..D = 0, word_valid = 0, busy = 0, err = 0, state IDLE, counter 0, shift register 0. Reset wins over every other event, including a mid-word reset; any partial word is dropped.
- A byte is accepted when enable and rx_done are both high at a rising edge.
- IDLE:
  - On byte accept: store rx_data in bits [7:0]; latch sel into sel_q; set count = 1.
  - If NBYTES == 1, go to COMMIT; otherwise go to COLLECT.
- COLLECT:
  - Each accepted byte k (0-based) goes to bits [8k+7:8k]; count increments.
  - When the byte that makes count == NBYTES is accepted, go to COMMIT.
  - Changes on sel after the first byte have no effect on the current word.
- COMMIT (one cycle):
  - At the next edge, the destination selected by sel_q loads the assembled word and word_valid[sel_q] is high for exactly one cycle.
  - Other destinations hold their values.
  - Latency: the last byte is accepted at edge N; the destination register and word_valid update at edge N+1.
  - A byte accepted during COMMIT is the first byte of the next word: it uses the current sel and moves to COLLECT with count 1. No byte is lost.
- enable low: no bytes are accepted; the counter, shift register and state are frozen. COMMIT still completes, so a word already finished is always delivered. Destination registers hold.
- Counter wrap cannot occur, because COMMIT always resets the count.
- busy = (state == COLLECT).

Optional Feature:
Macro: RX_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on each accepted byte and increments every enable-high cycle while in COLLECT.
  - If it reaches TIMEOUT_CYC-1 with no byte accepted, the partial word is discarded, err pulses for one cycle and the state returns to IDLE. Destinations are unchanged.
  - A byte accepted on the timeout cycle wins: it is taken as a normal byte and no err pulse is raised.
- Undefined: COLLECT waits indefinitely, no timeout counter is built, err is tied to 0.

Decomposition:
- Package uart_rx_pkg holds:
  - the state typedef (IDLE, COLLECT, COMMIT);
  - the destination select localparams (DST_A..DST_D, matching the TX mux select codes);
  - the NBYTES helper function.
- Sub-module: uart_byte_assembler, containing the shift register, byte counter and done flag. The FSM, routing and timeout stay in the top module.

Test Plan:
- LENGTH=32, sel=10, send 0x78, 0x56, 0x34, 0x12 -> C=0x12345678 one cycle after the last strobe; word_valid=0100 for one cycle; A, B, D remain 0.
- sel=00 for byte 0, then sel=11 for bytes 1-3, sending 0xEF, 0xBE, 0xAD, 0xDE -> A=0xDEADBEEF, D unchanged.
- Send 2 bytes, hold enable=0 for 50 cycles with rx_done pulses, then send 2 more bytes with enable=1 -> only the enabled bytes count; the word built from bytes 1, 2, 5, 6 lands in the selected destination.
- Assert rst after 3 bytes, then send a full word 0x11223344 to B -> B=0x11223344; no stale bytes appear in the word.
- Send a byte during the COMMIT cycle of the previous word -> the previous word is delivered correctly and the new byte becomes byte 0 of the next word.
- With RX_TIMEOUT_EN and TIMEOUT_CYC=20: send 2 bytes, then idle 25 cycles -> err pulses once, busy drops, destinations unchanged; a following full word is received correctly.
